multi_patgen: RTL

Multi-channel pattern generator: NCH independent pulse channels driven from one shared clock divider. Each channel has its own initial delay, separate high and low times, pulse count, run length and output polarity. Each channel runs either free (async) or triggered by the external `syncrst` edge (sync). It sits behind the byte-wide config bus and drives injection and test-pulse outputs toward the chip.

---
 rtl/multi_patgen_pkg.sv | 35 +++
 rtl/patgen_channel.sv | 164 ++++++++++++++++
 rtl/multi_patgen.sv | 88 ++++++++
 3 files changed

// File: rtl/multi_patgen_pkg.sv
// Shared definitions for the multi-channel pattern generator: register map,
// channel FSM states and the 16-bit timing field type.
package multi_patgen_pkg;

    typedef logic [15:0] field_t;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StHigh,
        StLow,
        StDone
    } chan_state_e;

    // Global register offsets (addr[AW-1] = 1)
    localparam logic [3:0] GlobClkfacHi = 4'd0;
    localparam logic [3:0] GlobClkfacLo = 4'd1;

    // Per-channel register offsets
    localparam logic [3:0] RegIdelayHi = 4'd0;
    localparam logic [3:0] RegIdelayLo = 4'd1;
    localparam logic [3:0] RegThighHi  = 4'd2;
    localparam logic [3:0] RegThighLo  = 4'd3;
    localparam logic [3:0] RegTlowHi   = 4'd4;
    localparam logic [3:0] RegTlowLo   = 4'd5;
    localparam logic [3:0] RegNpulses  = 4'd6;
    localparam logic [3:0] RegRunlenHi = 4'd7;
    localparam logic [3:0] RegRunlenLo = 4'd8;
    localparam logic [3:0] RegCtrl     = 4'd9;

    function automatic field_t clamp_one(input field_t v);
        return (v == '0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/patgen_channel.sv
// One pulse channel: config registers, working counters and the
// IDLE/DELAY/HIGH/LOW/DONE sequencer.
module patgen_channel
    import multi_patgen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       suspend,
    input  logic       tick,
    input  logic       trig,
    input  logic       synced,
    input  logic       wr_en,
    input  logic [3:0] wr_reg,
    input  logic [7:0] wr_data,
    output logic       out,
    output logic       running,
    output logic       done
);

    field_t     idelay_q, thigh_q, tlow_q, runlen_q;
    logic [7:0] npulses_q;
    logic       enable_q, invert_q;

    // Config registers hold their power-up value; rst deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (wr_reg)
                RegIdelayHi: idelay_q[15:8]  <= wr_data;
                RegIdelayLo: idelay_q[7:0]   <= wr_data;
                RegThighHi:  thigh_q[15:8]   <= wr_data;
                RegThighLo:  thigh_q[7:0]    <= wr_data;
                RegTlowHi:   tlow_q[15:8]    <= wr_data;
                RegTlowLo:   tlow_q[7:0]     <= wr_data;
                RegNpulses:  npulses_q       <= wr_data;
                RegRunlenHi: runlen_q[15:8]  <= wr_data;
                RegRunlenLo: runlen_q[7:0]   <= wr_data;
                RegCtrl: begin
                    enable_q <= wr_data[0];
                    invert_q <= wr_data[1];
                end
                default: ;
            endcase
        end
    end

    chan_state_e state_q, state_d;
    field_t      delay_q, delay_d;
    field_t      phase_q, phase_d;
    field_t      run_q, run_d;
    field_t      thigh_s_q, thigh_s_d;
    field_t      tlow_s_q, tlow_s_d;
    logic [7:0]  pulse_q, pulse_d;
    logic        inv_s_q, inv_s_d;
    logic        out_q, out_d;
    logic        run_inf_q;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        phase_d   = phase_q;
        run_d     = run_q;
        thigh_s_d = thigh_s_q;
        tlow_s_d  = tlow_s_q;
        pulse_d   = pulse_q;
        inv_s_d   = inv_s_q;

        if (!suspend) begin
            case (state_q)
                StIdle: begin
                    if (enable_q && (!synced || trig)) begin
                        state_d   = StDelay;
                        delay_d   = idelay_q;
                        pulse_d   = (npulses_q == 8'd0) ? 8'd1 : npulses_q;
                        thigh_s_d = clamp_one(thigh_q);
                        tlow_s_d  = clamp_one(tlow_q);
                        inv_s_d   = invert_q;
                    end
                end
                StDelay: begin
                    if (tick) begin
                        if (delay_q == '0) begin
                            state_d = StHigh;
                            phase_d = thigh_s_q - 16'd1;
                        end else begin
                            delay_d = delay_q - 16'd1;
                        end
                    end
                end
                StHigh: begin
                    if (tick) begin
                        if (phase_q != '0) begin
                            phase_d = phase_q - 16'd1;
                        end else if (pulse_q > 8'd1) begin
                            state_d = StLow;
                            phase_d = tlow_s_q - 16'd1;
                        end else begin
                            // Set ends; a finite run counter at 1 is the last set.
                            if (!run_inf_q && run_q <= 16'd1) begin
                                state_d = StDone;
                            end else begin
                                state_d = StIdle;
                            end
                            if (!run_inf_q) begin
                                run_d = run_q - 16'd1;
                            end
                        end
                    end
                end
                StLow: begin
                    if (tick) begin
                        if (phase_q == '0) begin
                            state_d = StHigh;
                            phase_d = thigh_s_q - 16'd1;
                            pulse_d = pulse_q - 8'd1;
                        end else begin
                            phase_d = phase_q - 16'd1;
                        end
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end

        // During a set the polarity comes from the start snapshot.
        if (suspend) begin
            out_d = out_q;
        end else if (state_d == StDelay || state_d == StHigh || state_d == StLow) begin
            out_d = (state_d == StHigh) ^ inv_s_d;
        end else begin
            out_d = invert_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            out_q     <= invert_q;
            run_q     <= runlen_q;
            run_inf_q <= (runlen_q == '0);
            delay_q   <= idelay_q;
            phase_q   <= '0;
            pulse_q   <= npulses_q;
            thigh_s_q <= clamp_one(thigh_q);
            tlow_s_q  <= clamp_one(tlow_q);
            inv_s_q   <= invert_q;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            run_q     <= run_d;
            delay_q   <= delay_d;
            phase_q   <= phase_d;
            pulse_q   <= pulse_d;
            thigh_s_q <= thigh_s_d;
            tlow_s_q  <= tlow_s_d;
            inv_s_q   <= inv_s_d;
        end
    end

    assign out     = out_q;
    assign running = (state_q == StDelay) || (state_q == StHigh) || (state_q == StLow);
    assign done    = (state_q == StDone);

endmodule

// File: rtl/multi_patgen.sv
// Multi-channel pattern generator top: config address decode, shared tick
// divider, syncrst synchroniser/edge detector and NCH channel instances.
module multi_patgen
    import multi_patgen_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 4 + $clog2(NCH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           suspend,
    input  logic           write,
    input  logic [AW-1:0]  addr,
    input  logic [7:0]     din,
    input  logic           synced,
    input  logic           syncrst,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] running,
    output logic [NCH-1:0] done
);

    field_t clkfac_q;

    always_ff @(posedge clk) begin
        if (write && addr[AW-1]) begin
            case (addr[3:0])
                GlobClkfacHi: clkfac_q[15:8] <= din;
                GlobClkfacLo: clkfac_q[7:0]  <= din;
                default: ;
            endcase
        end
    end

    field_t div_q;
    logic   tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= clkfac_q;
        end else if (!suspend) begin
            div_q <= (div_q == '0) ? clkfac_q : div_q - 16'd1;
        end
    end

    assign tick = (div_q == '0) && !suspend;

    logic sync1_q, sync2_q, edge_q;
    logic trig;

    // edge_q keeps tracking while suspended so that edges inside the window are lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= syncrst;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign trig = sync2_q && !edge_q && !suspend;

    logic [AW-2:0] ch_field;
    assign ch_field = addr[AW-2:0] >> 4;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic ch_wr;
        assign ch_wr = write && !addr[AW-1] && (ch_field == (AW-1)'(i));

        patgen_channel u_chan (
            .clk     (clk),
            .rst     (rst),
            .suspend (suspend),
            .tick    (tick),
            .trig    (trig),
            .synced  (synced),
            .wr_en   (ch_wr),
            .wr_reg  (addr[3:0]),
            .wr_data (din),
            .out     (out[i]),
            .running (running[i]),
            .done    (done[i])
        );
    end

endmodule
